// File: rtl/finish_responder.sv
// finish_responder: responder end of the cosim end-of-simulation handshake.
// It latches a finish request and its exit code, waits a fixed number of drain
// cycles, and then acknowledges with a 4-phase handshake. It reports done, the
// exit code and the cycle on which the request was accepted. A watchdog ends
// the run with a timeout status if no request arrives in time.

module finish_responder #(
   parameter int unsigned DRAIN_CYCLES   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned CODE_WIDTH     = 8,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter bit          CALL_FINISH    = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  finish_req,
   input  logic [CODE_WIDTH-1:0] finish_code,
   output logic                  finish_ack,
   output logic                  done,
   output logic                  timed_out,
   output logic [CODE_WIDTH-1:0] exit_code,
   output logic [CNT_WIDTH-1:0]  cycle_count,
   output logic [CNT_WIDTH-1:0]  finish_cycle
);

   // The drain counter only needs to hold DRAIN_CYCLES. It keeps one bit even
   // when draining is disabled, so the declaration stays legal.
   localparam int unsigned DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

   localparam logic [DRAIN_W-1:0]    DRAIN_LOAD  = DRAIN_W'(DRAIN_CYCLES);
   localparam logic [DRAIN_W-1:0]    DRAIN_LAST  = DRAIN_W'(1);
   localparam logic [CNT_WIDTH-1:0]  TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX     = '1;
   localparam logic [CODE_WIDTH-1:0] CODE_ONES   = '1;
   localparam bit                    WATCHDOG_EN = (TIMEOUT_CYCLES != 0);
   localparam bit                    NO_DRAIN    = (DRAIN_CYCLES == 0);

   // Controller states
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_ACK   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // A watchdog limit that the cycle counter can never reach is a configuration error
   if ((64'(TIMEOUT_CYCLES) >> CNT_WIDTH) != 64'd0) begin : g_timeout_width_check
      $error("finish_responder: TIMEOUT_CYCLES does not fit in CNT_WIDTH bits");
   end

   logic [1:0]            state_q,        state_d;
   logic [DRAIN_W-1:0]    drain_cnt_q,    drain_cnt_d;
   logic                  finish_ack_q,   finish_ack_d;
   logic                  done_q,         done_d;
   logic                  timed_out_q,    timed_out_d;
   logic [CODE_WIDTH-1:0] exit_code_q,    exit_code_d;
   logic [CNT_WIDTH-1:0]  cycle_count_q,  cycle_count_d;
   logic [CNT_WIDTH-1:0]  finish_cycle_q, finish_cycle_d;

   // Free-running cycle counter: saturates at all-ones and freezes once finished
   always_comb begin
      cycle_count_d = cycle_count_q;
      if ((state_q != ST_DONE) && (cycle_count_q != CNT_MAX)) begin
         cycle_count_d = cycle_count_q + CNT_WIDTH'(1);
      end
   end

   // Handshake controller: request capture, drain countdown, 4-phase ack, watchdog
   always_comb begin
      state_d        = state_q;
      drain_cnt_d    = drain_cnt_q;
      finish_ack_d   = finish_ack_q;
      done_d         = done_q;
      timed_out_d    = timed_out_q;
      exit_code_d    = exit_code_q;
      finish_cycle_d = finish_cycle_q;

      case (state_q)
         ST_IDLE: begin
            // A request beats a watchdog expiry on the same edge
            if (finish_req) begin
               exit_code_d    = finish_code;
               finish_cycle_d = cycle_count_q;
               if (NO_DRAIN) begin
                  finish_ack_d = 1'b1;
                  state_d      = ST_ACK;
               end else begin
                  drain_cnt_d = DRAIN_LOAD;
                  state_d     = ST_DRAIN;
               end
            end else if (WATCHDOG_EN && (cycle_count_q == TIMEOUT_VAL)) begin
               done_d         = 1'b1;
               timed_out_d    = 1'b1;
               exit_code_d    = CODE_ONES;
               finish_cycle_d = cycle_count_q;
               state_d        = ST_DONE;
            end
         end

         ST_DRAIN: begin
            // The request is already latched, so req and code are not looked at here
            drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
            if (drain_cnt_q == DRAIN_LAST) begin
               finish_ack_d = 1'b1;
               state_d      = ST_ACK;
            end
         end

         ST_ACK: begin
            // Hold the ack until the initiator withdraws its request
            if (!finish_req) begin
               finish_ack_d = 1'b0;
               done_d       = 1'b1;
               state_d      = ST_DONE;
            end
         end

         default: begin
            // Terminal: everything holds until reset
            state_d = ST_DONE;
         end
      endcase
   end

   // State registers; a low reset_n clears everything and overrides all else
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         drain_cnt_q    <= '0;
         finish_ack_q   <= 1'b0;
         done_q         <= 1'b0;
         timed_out_q    <= 1'b0;
         exit_code_q    <= '0;
         cycle_count_q  <= '0;
         finish_cycle_q <= '0;
      end else begin
         state_q        <= state_d;
         drain_cnt_q    <= drain_cnt_d;
         finish_ack_q   <= finish_ack_d;
         done_q         <= done_d;
         timed_out_q    <= timed_out_d;
         exit_code_q    <= exit_code_d;
         cycle_count_q  <= cycle_count_d;
         finish_cycle_q <= finish_cycle_d;
      end
   end

   assign finish_ack   = finish_ack_q;
   assign done         = done_q;
   assign timed_out    = timed_out_q;
   assign exit_code    = exit_code_q;
   assign cycle_count  = cycle_count_q;
   assign finish_cycle = finish_cycle_q;

`ifndef SYNTHESIS
   // Sanity properties: ack and done never coexist, and a timeout implies done
   property p_ack_excludes_done;
      @(posedge clk) disable iff (!reset_n) finish_ack_q |-> !done_q;
   endproperty
   property p_timeout_implies_done;
      @(posedge clk) disable iff (!reset_n) timed_out_q |-> done_q;
   endproperty
   a_ack_excludes_done:    assert property (p_ack_excludes_done);
   a_timeout_implies_done: assert property (p_timeout_implies_done);

   if (CALL_FINISH) begin : g_call_finish
      // Stop the simulation on the edge that enters DONE
      always_ff @(posedge clk) begin
         if (reset_n && (state_q != ST_DONE) && (state_d == ST_DONE)) begin
            $display("Finishing simulation... exit_code=0x%0h timed_out=%0b",
                     exit_code_d, timed_out_d);
            $finish;
         end
      end
   end
`endif

endmodule

// File: tb/tb_finish_responder.sv
// tb_finish_responder: scoreboard bench for finish_responder.
// Stimulus pushes the expected ack and done events into per-DUT queues. Monitors
// pop an entry and compare it whenever finish_ack or done rises.
// dut_a: DRAIN_CYCLES=4, TIMEOUT_CYCLES=20
// dut_b: DRAIN_CYCLES=0, watchdog disabled

module tb_finish_responder;

   typedef struct {
      bit          is_done;
      logic [7:0]  code;
      bit          tmo;
      logic [31:0] fc;
      logic [31:0] cc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_a_n, rst_b_n;
   logic        req_a, req_b;
   logic [7:0]  code_a, code_b;
   logic        ack_a, done_a, tmo_a;
   logic        ack_b, done_b, tmo_b;
   logic [7:0]  ex_a, ex_b;
   logic [31:0] cc_a, fc_a, cc_b, fc_b;

   logic ack_a_prev = 1'b0, done_a_prev = 1'b0;
   logic ack_b_prev = 1'b0, done_b_prev = 1'b0;

   exp_t qa[$];
   exp_t qb[$];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   finish_responder #(
      .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(20), .CODE_WIDTH(8), .CNT_WIDTH(32), .CALL_FINISH(1'b0)
   ) dut_a (
      .clk(clk), .reset_n(rst_a_n), .finish_req(req_a), .finish_code(code_a),
      .finish_ack(ack_a), .done(done_a), .timed_out(tmo_a), .exit_code(ex_a),
      .cycle_count(cc_a), .finish_cycle(fc_a)
   );

   finish_responder #(
      .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .CODE_WIDTH(8), .CNT_WIDTH(32), .CALL_FINISH(1'b0)
   ) dut_b (
      .clk(clk), .reset_n(rst_b_n), .finish_req(req_b), .finish_code(code_b),
      .finish_ack(ack_b), .done(done_b), .timed_out(tmo_b), .exit_code(ex_b),
      .cycle_count(cc_b), .finish_cycle(fc_b)
   );

   // Build one scoreboard entry
   function automatic exp_t mk(input bit d, input logic [7:0] c, input bit t,
                               input logic [31:0] f, input logic [31:0] n);
      exp_t e;
      e.is_done = d;
      e.code    = c;
      e.tmo     = t;
      e.fc      = f;
      e.cc      = n;
      return e;
   endfunction

   // Single comparison with a pass/fail count
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare one observed ack/done event against its queued expectation
   task automatic matchEvent(input string tag, input exp_t e, input bit is_done,
                             input logic [7:0] code, input bit tmo, input logic [31:0] fc,
                             input logic [31:0] cc, input logic ack);
      checkOutput({tag, "_kind"}, 32'(is_done), 32'(e.is_done));
      checkOutput({tag, "_exit_code"}, 32'(code), 32'(e.code));
      checkOutput({tag, "_timed_out"}, 32'(tmo), 32'(e.tmo));
      checkOutput({tag, "_finish_cycle"}, fc, e.fc);
      checkOutput({tag, "_cycle_count"}, cc, e.cc);
      if (is_done) checkOutput({tag, "_ack_low"}, 32'(ack), 32'd0);
   endtask

   // An event rose while nothing was expected
   task automatic noteUnexpected(input string tag);
      checks++;
      errors++;
      $display("[TB] FAIL %s: got unexpected rising event, expected none at %0t", tag, $time);
   endtask

   // Monitor for dut_a
   always @(negedge clk) begin
      if (ack_a && !ack_a_prev) begin
         if (qa.size() == 0) noteUnexpected("a_ack");
         else matchEvent("a_ack", qa.pop_front(), 1'b0, ex_a, tmo_a, fc_a, cc_a, ack_a);
      end
      if (done_a && !done_a_prev) begin
         if (qa.size() == 0) noteUnexpected("a_done");
         else matchEvent("a_done", qa.pop_front(), 1'b1, ex_a, tmo_a, fc_a, cc_a, ack_a);
      end
      ack_a_prev  <= ack_a;
      done_a_prev <= done_a;
   end

   // Monitor for dut_b
   always @(negedge clk) begin
      if (ack_b && !ack_b_prev) begin
         if (qb.size() == 0) noteUnexpected("b_ack");
         else matchEvent("b_ack", qb.pop_front(), 1'b0, ex_b, tmo_b, fc_b, cc_b, ack_b);
      end
      if (done_b && !done_b_prev) begin
         if (qb.size() == 0) noteUnexpected("b_done");
         else matchEvent("b_done", qb.pop_front(), 1'b1, ex_b, tmo_b, fc_b, cc_b, ack_b);
      end
      ack_b_prev  <= ack_b;
      done_b_prev <= done_b;
   end

   // Advance n clocks, landing 1 time unit after the rising edge
   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input bit sel_b, input logic req, input logic [7:0] code);
      if (sel_b) begin
         req_b  = req;
         code_b = code;
      end else begin
         req_a  = req;
         code_a = code;
      end
   endtask

   task automatic waitCount(input bit sel_b, input logic [31:0] target);
      for (int i = 0; i < 100; i++) begin
         if ((sel_b ? cc_b : cc_a) == target) return;
         tick(1);
      end
      checkOutput("wait_cycle_count", sel_b ? cc_b : cc_a, target);
   endtask

   task automatic waitAck(input bit sel_b);
      for (int i = 0; i < 50; i++) begin
         if (sel_b ? ack_b : ack_a) return;
         tick(1);
      end
      checkOutput("wait_ack_timeout", 32'(sel_b ? ack_b : ack_a), 32'd1);
   endtask

   task automatic waitDone(input bit sel_b);
      for (int i = 0; i < 60; i++) begin
         if (sel_b ? done_b : done_a) return;
         tick(1);
      end
      checkOutput("wait_done_timeout", 32'(sel_b ? done_b : done_a), 32'd1);
   endtask

   task automatic resetA();
      rst_a_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00);
      tick(2);
      rst_a_n = 1'b1;
   endtask

   task automatic checkAllZeroA(input string tag);
      checkOutput({tag, "_ack"}, 32'(ack_a), 32'd0);
      checkOutput({tag, "_done"}, 32'(done_a), 32'd0);
      checkOutput({tag, "_timed_out"}, 32'(tmo_a), 32'd0);
      checkOutput({tag, "_exit_code"}, 32'(ex_a), 32'd0);
      checkOutput({tag, "_cycle_count"}, cc_a, 32'd0);
      checkOutput({tag, "_finish_cycle"}, fc_a, 32'd0);
   endtask

   // Hard stop so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
      $fatal(1, "[TB] global timeout");
   end

   // Directed test sequence
   initial begin
      rst_a_n = 1'b0;
      rst_b_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0; code_a = 8'h00; code_b = 8'h00;
      tick(3);

      // Reset state
      checkAllZeroA("reset");
      checkOutput("reset_b_cycle_count", cc_b, 32'd0);
      checkOutput("reset_b_done", 32'(done_b), 32'd0);

      // Zero drain: ack on the accepting edge, then done and frozen count
      rst_b_n = 1'b1;
      waitCount(1'b1, 32'd3);
      applyStimulus(1'b1, 1'b1, 8'h7E);
      qb.push_back(mk(1'b0, 8'h7E, 1'b0, 32'd3, 32'd4));
      qb.push_back(mk(1'b1, 8'h7E, 1'b0, 32'd3, 32'd5));
      waitAck(1'b1);
      applyStimulus(1'b1, 1'b0, 8'h7E);
      waitDone(1'b1);
      tick(5);
      checkOutput("b_cycle_count_frozen", cc_b, 32'd5);
      checkOutput("b_ack_after_done", 32'(ack_b), 32'd0);

      // Directed request at cycle_count=10, ack four edges after acceptance
      rst_a_n = 1'b1;
      waitCount(1'b0, 32'd10);
      applyStimulus(1'b0, 1'b1, 8'h2A);
      qa.push_back(mk(1'b0, 8'h2A, 1'b0, 32'd10, 32'd15));
      qa.push_back(mk(1'b1, 8'h2A, 1'b0, 32'd10, 32'd16));
      waitAck(1'b0);
      applyStimulus(1'b0, 1'b0, 8'h2A);
      waitDone(1'b0);

      // Post-done request is ignored
      applyStimulus(1'b0, 1'b1, 8'h11);
      tick(2);
      applyStimulus(1'b0, 1'b0, 8'h11);
      tick(3);
      checkOutput("post_done_ack", 32'(ack_a), 32'd0);
      checkOutput("post_done_exit_code", 32'(ex_a), 32'h2A);
      checkOutput("post_done_finish_cycle", fc_a, 32'd10);
      checkOutput("post_done_cycle_count", cc_a, 32'd16);
      checkOutput("post_done_done", 32'(done_a), 32'd1);

      // One-cycle request glitch, code changes during drain
      resetA();
      waitCount(1'b0, 32'd5);
      applyStimulus(1'b0, 1'b1, 8'h05);
      qa.push_back(mk(1'b0, 8'h05, 1'b0, 32'd5, 32'd10));
      qa.push_back(mk(1'b1, 8'h05, 1'b0, 32'd5, 32'd11));
      tick(1);
      applyStimulus(1'b0, 1'b0, 8'h09);
      waitDone(1'b0);

      // Watchdog with no request
      resetA();
      qa.push_back(mk(1'b1, 8'hFF, 1'b1, 32'd20, 32'd21));
      waitDone(1'b0);
      tick(2);
      checkOutput("wd_ack", 32'(ack_a), 32'd0);

      // Request arriving exactly at the timeout value wins
      resetA();
      waitCount(1'b0, 32'd20);
      applyStimulus(1'b0, 1'b1, 8'h3C);
      qa.push_back(mk(1'b0, 8'h3C, 1'b0, 32'd20, 32'd25));
      qa.push_back(mk(1'b1, 8'h3C, 1'b0, 32'd20, 32'd26));
      waitAck(1'b0);
      applyStimulus(1'b0, 1'b0, 8'h3C);
      waitDone(1'b0);

      // Reset during drain aborts with no ack, then a fresh request completes
      resetA();
      waitCount(1'b0, 32'd3);
      applyStimulus(1'b0, 1'b1, 8'h44);
      tick(2);
      rst_a_n = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'h00);
      tick(1);
      checkAllZeroA("rst_drain");
      rst_a_n = 1'b1;
      tick(1);
      checkOutput("rst_drain_cc_restart", cc_a, 32'd1);
      waitCount(1'b0, 32'd4);
      applyStimulus(1'b0, 1'b1, 8'h55);
      qa.push_back(mk(1'b0, 8'h55, 1'b0, 32'd4, 32'd9));
      qa.push_back(mk(1'b1, 8'h55, 1'b0, 32'd4, 32'd10));
      waitAck(1'b0);
      applyStimulus(1'b0, 1'b0, 8'h55);
      waitDone(1'b0);

      // Reset during ack drops ack and never reports done
      resetA();
      waitCount(1'b0, 32'd2);
      applyStimulus(1'b0, 1'b1, 8'h66);
      qa.push_back(mk(1'b0, 8'h66, 1'b0, 32'd2, 32'd7));
      waitAck(1'b0);
      rst_a_n = 1'b0;
      tick(1);
      checkAllZeroA("rst_ack");
      rst_a_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00);
      tick(1);
      checkOutput("rst_ack_cc_restart", cc_a, 32'd1);
      waitCount(1'b0, 32'd6);
      applyStimulus(1'b0, 1'b1, 8'h77);
      qa.push_back(mk(1'b0, 8'h77, 1'b0, 32'd6, 32'd11));
      qa.push_back(mk(1'b1, 8'h77, 1'b0, 32'd6, 32'd12));
      waitAck(1'b0);
      applyStimulus(1'b0, 1'b0, 8'h77);
      waitDone(1'b0);

      // Every expected event must have been observed
      tick(3);
      checkOutput("a_queue_drained", 32'(qa.size()), 32'd0);
      checkOutput("b_queue_drained", 32'(qb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
